// File: rtl/muldiv_sequencer_pkg.sv
// Shared decode constants and FSM state type for the multiply/divide unit.
//   ALUOP_*   : EX-stage ALUop encodings
//   F_*       : R-type funct codes served by the unit
//   md_state_e: sequencer states
//   is_md_func: true for any HI/LO-class funct code
package muldiv_sequencer_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_e;

    function automatic logic is_md_func(input logic [5:0] f);
        return (f inside {[F_MFHI:F_MTLO], [F_MULT:F_DIVU]});
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide unit bundle.
//   master : EX side (drives instruction fields, observes stall/result/HI/LO)
//   slave  : the multiply/divide unit
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             ex_valid;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             ex_flush;
    logic             md_stall;
    logic             md_busy;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    modport master (
        output ex_valid, alu_op, func, rs_val, rt_val, ex_flush,
        input  md_stall, md_busy, md_result, hi_q, lo_q
    );

    modport slave (
        input  ex_valid, alu_op, func, rs_val, rt_val, ex_flush,
        output md_stall, md_busy, md_result, hi_q, lo_q
    );
endinterface

// File: rtl/muldiv_sequencer_mdu_core.sv
// Iterative unsigned datapath: shift-add multiply / restoring divide.
//   clk, rst  : clock, synchronous active-high reset
//   init      : load operands, counter = WIDTH-1
//   step      : perform one iteration
//   div_mode  : sampled at init; 1 = divide, 0 = multiply
//   a, b      : multiplicand/multiplier or dividend/divisor (magnitudes)
//   acc       : multiply -> 2*WIDTH product; divide -> {remainder, quotient}
//   done      : counter has reached zero (current step is the last one)
module mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               done
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    logic             mode_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_part;
    logic [WIDTH+1:0] div_diff;

    // Multiply: acc = {partial product, remaining multiplier bits}; the LSB
    // selects whether the multiplicand is added before the right shift.
    // Divide: acc = {partial remainder, dividend bits / quotient bits}; the
    // next dividend bit is shifted into the remainder and the divisor is
    // trial-subtracted. The extra top bit of div_diff is the borrow.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_diff = {1'b0, div_part} - {2'b00, opnd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            mode_div <= 1'b0;
        end else if (init) begin
            cnt      <= CW'(WIDTH - 1);
            mode_div <= div_mode;
            opnd     <= div_mode ? b : a;
            acc      <= {{WIDTH{1'b0}}, (div_mode ? a : b)};
        end else if (step) begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (mode_div) begin
                if (!div_diff[WIDTH+1])
                    acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU; owns HI/LO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of muldiv_sequencer_if
//              in : ex_valid, alu_op, func, rs_val, rt_val, ex_flush
//              out: md_stall, md_busy, md_result (comb), hi_q, lo_q
// Decode, stall, sequencing FSM, sign fix-up and HI/LO live here; the
// iterative arithmetic is in mdu_core.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    md_state_e        state;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rs_raw;
    logic             op_div;
    logic             div_zero;
    logic             neg_q;
    logic             neg_r;

    logic               md_op;
    logic               accept;
    logic               signed_op;
    logic               rt_zero;
    logic [WIDTH-1:0]   abs_rs;
    logic [WIDTH-1:0]   abs_rt;
    logic               core_step;
    logic               core_done;
    logic [2*WIDTH-1:0] core_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // funct[3] separates mult/div (0x18..0x1B) from moves (0x10..0x13);
    // funct[1] picks divide, funct[0] clear means signed.
    always_comb begin
        md_op     = bus.ex_valid && !bus.ex_flush && (bus.alu_op == ALUOP_R)
                    && is_md_func(bus.func);
        accept    = md_op && !busy && bus.func[3];
        signed_op = !bus.func[0];
        rt_zero   = (bus.rt_val == '0);
        abs_rs    = (signed_op && bus.rs_val[WIDTH-1]) ? (~bus.rs_val + 1'b1) : bus.rs_val;
        abs_rt    = (signed_op && bus.rt_val[WIDTH-1]) ? (~bus.rt_val + 1'b1) : bus.rt_val;
        core_step = (state == MUL) || (state == DIV);
        prod_fix  = neg_q ? (~core_acc + 1'b1) : core_acc;
        q_fix     = neg_q ? (~core_acc[WIDTH-1:0] + 1'b1) : core_acc[WIDTH-1:0];
        r_fix     = neg_r ? (~core_acc[2*WIDTH-1:WIDTH] + 1'b1) : core_acc[2*WIDTH-1:WIDTH];
    end

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .init     (accept),
        .step     (core_step),
        .div_mode (bus.func[1]),
        .a        (abs_rs),
        .b        (abs_rt),
        .acc      (core_acc),
        .done     (core_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            rs_raw   <= '0;
            op_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy     <= 1'b1;
                        rs_raw   <= bus.rs_val;
                        op_div   <= bus.func[1];
                        div_zero <= bus.func[1] && rt_zero;
                        // neg_q: product sign for mult, quotient sign for div
                        neg_q    <= signed_op && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                        neg_r    <= signed_op && bus.rs_val[WIDTH-1];
                        if (!bus.func[1])
                            state <= MUL;
                        else if (rt_zero)
                            state <= FIX;   // divide by zero skips the iterations
                        else
                            state <= DIV;
                    end else if (md_op && bus.func == F_MTHI) begin
                        hi <= bus.rs_val;
                    end else if (md_op && bus.func == F_MTLO) begin
                        lo <= bus.rs_val;
                    end
                end
                MUL, DIV: begin
                    if (core_done)
                        state <= FIX;
                end
                FIX: begin
                    if (!op_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        hi <= rs_raw;
                        lo <= '1;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.md_stall  = md_op && busy;
    assign bus.md_busy   = busy;
    assign bus.hi_q      = hi;
    assign bus.lo_q      = lo;
    assign bus.md_result = (md_op && !busy && bus.func == F_MFHI) ? hi :
                           (md_op && !busy && bus.func == F_MFLO) ? lo : '0;
endmodule
